// File: rtl/cpu_pkg.sv
// Purpose: shared widths, halt opcode and fetch FSM state type for the fetch slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents: ADDR_W / INST_W / OPC_W widths, HALT_OPCODE, fetch_state_e,
// opcode_of() and is_halt() helpers used by the fetch unit.
package cpu_pkg;

    localparam int ADDR_W = 64;
    localparam int INST_W = 32;
    localparam int OPC_W  = 11;

    // Top eleven instruction bits of the halt encoding.
    localparam logic [OPC_W-1:0]  HALT_OPCODE = 11'h7FF;

    // Instructions are fixed-size, word aligned.
    localparam logic [ADDR_W-1:0] INST_BYTES  = 64'd4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ISSUE  = 3'd1,
        WAIT   = 3'd2,
        HOLD   = 3'd3,
        HALTED = 3'd4
    } fetch_state_e;

    // Opcode field that feeds the control decoder.
    function automatic logic [OPC_W-1:0] opcode_of(input logic [INST_W-1:0] inst);
        return inst[INST_W-1 -: OPC_W];
    endfunction

    function automatic logic is_halt(input logic [INST_W-1:0] inst);
        return opcode_of(inst) == HALT_OPCODE;
    endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// Purpose: bundles the fetch unit's memory, decode and redirect signals.
// Latency: n/a (wiring only).
// Backpressure: decode stalls fetch via id_ready; memory returns via imem_valid.
//
// master = fetch unit side, slave = memory / decode / branch side.
//   imem_req/imem_addr   : one-cycle fetch request and its address
//   imem_valid/imem_rdata: returned instruction word strobe and data
//   inst_out/inst31_21/inst_valid/pc_out/id_ready : held instruction to decode
//   br_taken/br_target   : single-cycle redirect from branch resolution
//   halted               : sticky halt indication
interface cpu_fetch_if;
    import cpu_pkg::*;

    logic                 imem_req;
    logic [ADDR_W-1:0]    imem_addr;
    logic                 imem_valid;
    logic [INST_W-1:0]    imem_rdata;

    logic [INST_W-1:0]    inst_out;
    logic [OPC_W-1:0]     inst31_21;
    logic                 inst_valid;
    logic                 id_ready;
    logic [ADDR_W-1:0]    pc_out;

    logic                 br_taken;
    logic [ADDR_W-1:0]    br_target;

    logic                 halted;

    modport master (
        output imem_req, imem_addr,
        input  imem_valid, imem_rdata,
        output inst_out, inst31_21, inst_valid, pc_out,
        input  id_ready,
        input  br_taken, br_target,
        output halted
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_valid, imem_rdata,
        input  inst_out, inst31_21, inst_valid, pc_out,
        output id_ready,
        output br_taken, br_target,
        input  halted
    );

endinterface

// File: rtl/cpu_pc_reg.sv
// Purpose: program counter register with +4 increment and branch redirect mux.
// Latency: 1 cycle from redirect/advance to pc; pc_nxt is the same-cycle next value.
// Backpressure: none; holds its value unless redirect or advance is asserted.
//
// Ports: clk, rst_n, redirect + target (highest priority, low two bits cleared),
// advance (step to next sequential instruction), pc (current), pc_nxt (next).
module cpu_pc_reg
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] target,
    input  logic              advance,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_nxt
);

    // Sequential step relies on natural 64-bit wrap past the top of memory.
    always_comb begin
        pc_nxt = pc;
        if (redirect) begin
            pc_nxt = {target[ADDR_W-1:2], 2'b00};
        end else if (advance) begin
            pc_nxt = pc + INST_BYTES;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else begin
            pc <= pc_nxt;
        end
    end

endmodule

// File: rtl/cpu_fetch.sv
// Purpose: single-outstanding instruction fetch FSM feeding the decode stage.
// Latency: ISSUE -> WAIT (>=1 cycle of memory latency) -> HOLD; best case one instruction per 3-4 cycles.
// Backpressure: HOLD keeps inst_out/pc_out/inst_valid until id_ready; no new request is made meanwhile.
//
// Ports: clk, rst_n (async, active low), bus (cpu_fetch_if.master) carrying the
// memory request/return, decode handshake, branch redirect and halted flag.
// All outputs are registered.
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    cpu_fetch_if.master bus
);

    fetch_state_e       state;
    logic               squash;
    logic               req_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [INST_W-1:0]  inst_q;
    logic [ADDR_W-1:0]  pc_out_q;
    logic               inst_vld_q;
    logic               halted_q;

    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W-1:0]  pc_nxt;
    logic               redirect;
    logic               advance;
    logic               take_data;

    // A halted core no longer follows branches.
    assign redirect  = bus.br_taken && (state != HALTED);

    // Returned word is kept only if no redirect has made it stale.
    assign take_data = (state == WAIT) && bus.imem_valid && !squash && !bus.br_taken;
    assign advance   = take_data;

    cpu_pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .redirect (redirect),
        .target   (bus.br_target),
        .advance  (advance),
        .pc       (pc),
        .pc_nxt   (pc_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            squash     <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= '0;
            inst_q     <= '0;
            pc_out_q   <= '0;
            inst_vld_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            // Request is a pulse: only the cycle spent in ISSUE sees it high.
            req_q <= 1'b0;

            unique case (state)
                IDLE: begin
                    // The first request uses the pc as it stands now; a
                    // coincident redirect makes that fetch stale.
                    state  <= ISSUE;
                    req_q  <= 1'b1;
                    addr_q <= pc;
                    squash <= bus.br_taken;
                end

                ISSUE: begin
                    // Address was latched on entry, so a redirect here only
                    // moves the pc and marks the in-flight fetch stale.
                    state <= WAIT;
                    if (bus.br_taken) begin
                        squash <= 1'b1;
                    end
                end

                WAIT: begin
                    if (bus.imem_valid) begin
                        if (bus.br_taken || squash) begin
                            // Drop the word and refetch from the (new) pc.
                            squash <= 1'b0;
                            state  <= ISSUE;
                            req_q  <= 1'b1;
                            addr_q <= pc_nxt;
                        end else begin
                            inst_q     <= bus.imem_rdata;
                            pc_out_q   <= pc;
                            inst_vld_q <= 1'b1;
                            state      <= HOLD;
                        end
                    end else if (bus.br_taken) begin
                        squash <= 1'b1;
                    end
                end

                HOLD: begin
                    // Redirect wins over the handshake; either way the held
                    // word is gone after this edge.
                    if (bus.br_taken || bus.id_ready) begin
                        inst_vld_q <= 1'b0;
                        if (!bus.br_taken && is_halt(inst_q)) begin
                            state    <= HALTED;
                            halted_q <= 1'b1;
                        end else begin
                            state  <= ISSUE;
                            req_q  <= 1'b1;
                            addr_q <= pc_nxt;
                        end
                    end
                end

                HALTED: begin
                    // Terminal until reset.
                    state <= HALTED;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.imem_req   = req_q;
    assign bus.imem_addr  = addr_q;
    assign bus.inst_out   = inst_q;
    assign bus.inst31_21  = opcode_of(inst_q);
    assign bus.inst_valid = inst_vld_q;
    assign bus.pc_out     = pc_out_q;
    assign bus.halted     = halted_q;

endmodule

// File: doc/cpu_fetch.md
CPU_FETCH -- requirements
Module: cpu_fetch

Interface
REQ-001 Parameter RESET_PC, default 64'h0, PC value loaded on reset.
REQ-002 Port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 Port rst_n, input, 1, reset; asynchronous assert, active-low.
REQ-004 Port imem_req, output, 1, one-cycle fetch request pulse.
REQ-005 Port imem_addr, output, 64, fetch address, valid while imem_req=1.
REQ-006 Port imem_valid, input, 1, read data return strobe, >=1 cycle after imem_req.
REQ-007 Port imem_rdata, input, 32, returned instruction word.
REQ-008 Port inst_out, output, 32, held instruction for decode.
REQ-009 Port inst31_21, output, 11, equals inst_out[31:21]; feeds the control decoder.
REQ-010 Port inst_valid, output, 1, inst_out valid to decode.
REQ-011 Port id_ready, input, 1, decode accepts inst_out when inst_valid and id_ready are both 1.
REQ-012 Port pc_out, output, 64, address of the instruction in inst_out.
REQ-013 Port br_taken, input, 1, single-cycle redirect strobe from branch resolution.
REQ-014 Port br_target, input, 64, redirect address, sampled when br_taken=1.
REQ-015 Port halted, output, 1, set after HALT is accepted; sticky until reset.

Function
REQ-016 FSM states: IDLE, ISSUE, WAIT, HOLD, HALTED.
REQ-017 IDLE SHALL move to ISSUE unconditionally on the next edge.
REQ-018 ISSUE SHALL drive imem_req=1 and imem_addr=pc for exactly one cycle, then move to WAIT.
REQ-019 At most one request SHALL be outstanding; imem_req=0 in every state except ISSUE.
REQ-020 WAIT with imem_valid=1 and no squash SHALL capture inst_out<=imem_rdata and pc_out<=pc, set inst_valid=1, set pc<=pc+4, and move to HOLD.
REQ-021 HOLD SHALL hold inst_out, pc_out, and inst_valid stable until the handshake.
REQ-022 On the handshake, HOLD SHALL clear inst_valid and move to ISSUE, or to HALTED if inst31_21==11'h7FF.
REQ-023 HALTED SHALL keep halted=1 and imem_req=0, and SHALL ignore br_taken and imem_valid.
REQ-024 br_taken SHALL have the highest priority and SHALL load pc<=br_target with bits [1:0] forced to 00.
REQ-025 br_taken in HOLD SHALL clear inst_valid and move to ISSUE; a coincident handshake counts as consumed.
REQ-026 br_taken in WAIT without imem_valid SHALL set the squash flag and stay in WAIT.
REQ-027 WAIT with imem_valid=1 and squash set SHALL discard the data, clear squash, and move to ISSUE.
REQ-028 br_taken in WAIT coincident with imem_valid SHALL discard the data and move to ISSUE.
REQ-029 br_taken in IDLE or ISSUE SHALL update pc only; the request in flight uses the old pc, and squash SHALL be set.
REQ-030 pc+4 SHALL wrap modulo 2^64.
REQ-031 Minimum throughput: one instruction per 4 cycles (ISSUE, WAIT, HOLD, handshake).

Reset
REQ-032 rst_n=0 SHALL force state=IDLE, pc=RESET_PC, squash=0, inst_out=0, pc_out=0, inst_valid=0, imem_req=0, halted=0.
REQ-033 Reset mid-request SHALL abandon the outstanding fetch; a stale imem_valid in IDLE or ISSUE SHALL be ignored.

Structure
REQ-034 Package cpu_pkg SHALL hold ADDR_W=64, INST_W=32, HALT_OPCODE=11'h7FF, and the fetch FSM state type.
REQ-035 The PC register with its increment and redirect mux SHALL be a sub-module cpu_pc_reg; all other logic is inline.

Verification
REQ-036 Reset release with a memory of 2-cycle latency and id_ready=1 -> imem_addr=0,4,8 in successive ISSUE cycles, and inst_out matches the memory words.
REQ-037 id_ready=0 for 5 cycles in HOLD -> inst_out and pc_out stable, and no imem_req pulse until one cycle after id_ready=1.
REQ-038 br_taken with br_target=64'h103 during WAIT, data returning 3 cycles later -> data discarded, next imem_addr=64'h100, and inst_valid stays 0 throughout.
REQ-039 Memory word 32'hFFE00000 fetched and accepted -> halted=1, then imem_req=0 for 20 cycles, and br_taken ignored.
REQ-040 RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch address 64'h0.
REQ-041 rst_n deasserted during WAIT, then imem_valid pulses in IDLE -> the pulse is ignored and fetch restarts at RESET_PC.
